// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: arbiter states, the fetch
// access type and requester identities.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_EX = 2'd1,
        ARB_GNT_IF = 2'd2
    } arb_state_e;

    localparam logic [2:0] DATATYPE_WORD = 3'b010;

    localparam logic REQ_ID_EX = 1'b0;
    localparam logic REQ_ID_IF = 1'b1;

    // EX has priority unless fetch has been starved long enough.
    function automatic logic arb_winner(input logic ex_req, input logic if_req,
                                        input logic starved);
        return (if_req && (!ex_req || starved)) ? REQ_ID_IF : REQ_ID_EX;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_timeout_cnt.sv
// Saturating up-counter with synchronous clear; o_expire is high while the
// count sits at MAX.
module arb_timeout_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    logic [W-1:0] r_cnt;

    // Count register: clear has priority, increment stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between EX loads/stores and instruction
// fetch, with starvation protection, response timeout and fetch flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DTYPE_W    = 3,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_r_en_i,
    input  logic               ex_w_en_i,
    input  logic [ADDR_W-1:0]  ex_addr_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic [DTYPE_W-1:0] ex_dtype_i,
    output logic [DATA_W-1:0]  ex_rdata_o,
    output logic               ex_done_o,
    output logic               ex_stall_o,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    input  logic               if_flush_i,
    output logic [DATA_W-1:0]  if_rdata_o,
    output logic               if_done_o,
    output logic               if_stall_o,
    output logic               s_req_o,
    output logic               s_we_o,
    output logic [ADDR_W-1:0]  s_addr_o,
    output logic [DATA_W-1:0]  s_wdata_o,
    output logic [DTYPE_W-1:0] s_dtype_o,
    input  logic               s_ack_i,
    input  logic [DATA_W-1:0]  s_rdata_i,
    output logic               err_o
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TO_W     = $clog2(TIMEOUT);

    arb_state_e r_state, w_state_nxt;

    logic w_ex_req, w_in_gnt, w_ack_ex, w_ack_if;
    logic w_grant, w_gnt_if, w_abort, w_starved, w_expire;

    logic               r_req, r_we, r_ex_done, r_if_done, r_err, r_flush;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata, r_ex_rdata, r_if_rdata;
    logic [DTYPE_W-1:0] r_dtype;

    assign w_ex_req = ex_r_en_i | ex_w_en_i;
    assign w_in_gnt = (r_state != ARB_IDLE);
    assign w_ack_ex = (r_state == ARB_GNT_EX) & s_ack_i;
    assign w_ack_if = (r_state == ARB_GNT_IF) & s_ack_i;

    arb_timeout_cnt #(.W(STARVE_W), .MAX(STARVE_W'(STARVE_MAX))) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_grant & w_gnt_if),
        .i_inc    (w_grant & ~w_gnt_if & if_req_i),
        .o_expire (w_starved)
    );

    // Expires on the TIMEOUT-th consecutive unacknowledged cycle of a grant.
    arb_timeout_cnt #(.W(TO_W), .MAX(TO_W'(TIMEOUT - 1))) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (~w_in_gnt),
        .i_inc    (w_in_gnt & ~s_ack_i),
        .o_expire (w_expire)
    );

    // Next-state and grant decode; an ack takes precedence over a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_if    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_ex_req || if_req_i) begin
                    w_grant     = 1'b1;
                    w_gnt_if    = (arb_winner(w_ex_req, if_req_i, w_starved) == REQ_ID_IF);
                    w_state_nxt = w_gnt_if ? ARB_GNT_IF : ARB_GNT_EX;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_GNT_EX, ARB_GNT_IF: begin
                if (s_ack_i) begin
                    w_state_nxt = ARB_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ARB_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory port registers: captured on grant, request held until ack or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dtype <= '0;
        end else if (w_grant) begin
            r_req   <= 1'b1;
            r_we    <= ~w_gnt_if & ex_w_en_i;
            r_addr  <= w_gnt_if ? if_addr_i : ex_addr_i;
            r_wdata <= w_gnt_if ? '0 : ex_wdata_i;
            r_dtype <= w_gnt_if ? DTYPE_W'(DATATYPE_WORD) : ex_dtype_i;
        end else if (w_in_gnt && (w_state_nxt == ARB_IDLE)) begin
            r_req   <= 1'b0;
        end else begin
            r_req   <= r_req;
        end
    end

    // Response path: done/err pulses, returned data and the fetch flush flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_done  <= 1'b0;
            r_if_done  <= 1'b0;
            r_err      <= 1'b0;
            r_flush    <= 1'b0;
            r_ex_rdata <= '0;
            r_if_rdata <= '0;
        end else begin
            r_ex_done <= w_ack_ex;
            r_if_done <= w_ack_if & ~(r_flush | if_flush_i);
            r_err     <= w_abort;
            if ((r_state == ARB_GNT_IF) && (w_state_nxt == ARB_GNT_IF)) begin
                r_flush <= r_flush | if_flush_i;
            end else begin
                r_flush <= 1'b0;
            end
            if (w_ack_ex && !r_we) begin
                r_ex_rdata <= s_rdata_i;
            end else begin
                r_ex_rdata <= r_ex_rdata;
            end
            if (w_ack_if) begin
                r_if_rdata <= s_rdata_i;
            end else begin
                r_if_rdata <= r_if_rdata;
            end
        end
    end

    assign s_req_o    = r_req;
    assign s_we_o     = r_we;
    assign s_addr_o   = r_addr;
    assign s_wdata_o  = r_wdata;
    assign s_dtype_o  = r_dtype;
    assign ex_rdata_o = r_ex_rdata;
    assign ex_done_o  = r_ex_done;
    assign if_rdata_o = r_if_rdata;
    assign if_done_o  = r_if_done;
    assign err_o      = r_err;
    assign ex_stall_o = w_ex_req & ~r_ex_done;
    assign if_stall_o = if_req_i & ~r_if_done & ~if_flush_i;

endmodule
